spi_txn_arbiter: RTL and testbench

Shares one SPI core between several host-side requesters. Arbitrates 32-bit transfer words into the write FIFO that feeds `spi_core`, and records the issuing requester of each word in an in-order tag queue. Routes each word returned through the read FIFO back to the requester that issued it. Sits in the 120 MHz domain, between requester ports (Avalon slave plus future masters) and the write-side/read-side ports of the two dual-clock FIFOs.

---
 rtl/spi_txn_arbiter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one SPI core between N_REQ host-side requesters.
//   * Issue side: round-robin arbitration of transfer words into the write
//     FIFO that feeds the SPI core.  The index of every issued word is pushed
//     into an in-order tag queue.
//   * Response side: each word returned through the read FIFO is handed back
//     to the requester at the head of the tag queue.  A word that arrives with
//     no outstanding tag is dropped and flagged in a sticky error bit.
//
// Ports
//   clk, reset_n         : single clock, synchronous active-low reset
//   req_valid/req_data   : requester words (requester i at [i*DATA_W +: DATA_W])
//   req_ready            : one-cycle one-hot accept pulse
//   rsp_valid/rsp_data   : one-cycle one-hot response pulse plus shared data
//   wr_fifo_*            : write side of the write FIFO
//   rd_fifo_*            : read side of the read FIFO (non-show-ahead)
//   outstanding          : words issued and not yet returned
//   err_orphan, err_clr  : sticky orphan flag and its clear
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         wr_fifo_wrreq,
    output logic [DATA_W-1:0]            wr_fifo_data,
    input  logic                         wr_fifo_full,
    output logic                         rd_fifo_rdreq,
    input  logic [DATA_W-1:0]            rd_fifo_q,
    input  logic                         rd_fifo_empty,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         err_orphan,
    input  logic                         err_clr
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
    localparam logic [IDX_W:0]   N_REQ_X  = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } iss_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_CAP  = 2'd2,
        R_OUT  = 2'd3
    } rsp_state_t;

    // Issue side state and registered outputs
    iss_state_t              r_iss_state;
    iss_state_t              w_iss_state_nxt;
    logic [N_REQ-1:0]        r_req_ready;
    logic [N_REQ-1:0]        w_req_ready_nxt;
    logic                    r_wrreq;
    logic                    w_wrreq_nxt;
    logic [DATA_W-1:0]       r_wr_data;
    logic [DATA_W-1:0]       w_wr_data_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_rr_ptr_nxt;
    logic [IDX_W-1:0]        r_iss_idx;
    logic [IDX_W-1:0]        w_iss_idx_nxt;
    logic                    w_push;

    // Round-robin search result
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick;

    // Response side state and registered outputs
    rsp_state_t              r_rsp_state;
    rsp_state_t              w_rsp_state_nxt;
    logic                    r_rdreq;
    logic                    w_rdreq_nxt;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [N_REQ-1:0]        w_rsp_valid_nxt;
    logic [DATA_W-1:0]       r_rsp_data;
    logic [DATA_W-1:0]       w_rsp_data_nxt;
    logic                    w_pop;
    logic                    w_orphan;

    // Tag queue
    logic [IDX_W-1:0]        r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_outstanding;
    logic [IDX_W-1:0]        w_head;

    logic                    r_err_orphan;

    assign req_ready     = r_req_ready;
    assign wr_fifo_wrreq = r_wrreq;
    assign wr_fifo_data  = r_wr_data;
    assign rd_fifo_rdreq = r_rdreq;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign outstanding   = r_outstanding;
    assign err_orphan    = r_err_orphan;
    assign w_head        = r_tag_mem[r_rd_ptr];

    // Round-robin search: first valid requester at or after r_rr_ptr, circularly
    always_comb begin
        logic [IDX_W:0]   v_sum;
        logic [IDX_W-1:0] v_cand;
        w_found = 1'b0;
        w_pick  = '0;
        v_sum   = '0;
        v_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_sum   = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            v_sum   = (v_sum >= N_REQ_X) ? (v_sum - N_REQ_X) : v_sum;
            v_cand  = v_sum[IDX_W-1:0];
            w_pick  = (!w_found && req_valid[v_cand]) ? v_cand : w_pick;
            w_found = w_found | req_valid[v_cand];
        end
    end

    // Issue FSM next state and next registered outputs
    always_comb begin
        w_iss_state_nxt = r_iss_state;
        w_req_ready_nxt = '0;
        w_wrreq_nxt     = 1'b0;
        w_wr_data_nxt   = r_wr_data;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_iss_idx_nxt   = r_iss_idx;
        w_push          = 1'b0;
        case (r_iss_state)
            ARB: begin
                // Capacity is checked here only; ISSUE always completes the
                // write because this registered decision reserved the slot.
                if (w_found && !wr_fifo_full && (r_outstanding != FULL_CNT)) begin
                    w_iss_state_nxt          = ISSUE;
                    w_req_ready_nxt[w_pick]  = 1'b1;
                    w_wrreq_nxt              = 1'b1;
                    w_wr_data_nxt            = req_data[w_pick*DATA_W +: DATA_W];
                    w_iss_idx_nxt            = w_pick;
                    w_rr_ptr_nxt             = (w_pick == LAST_IDX) ? '0 : (w_pick + IDX_W'(1));
                end else begin
                    w_iss_state_nxt = ARB;
                end
            end
            ISSUE: begin
                // The accept pulse is on the wire this cycle; the held
                // request is not looked at again until the next ARB cycle.
                w_iss_state_nxt = ARB;
                w_push          = 1'b1;
            end
            default: begin
                w_iss_state_nxt = ARB;
            end
        endcase
    end

    // Issue FSM state register and its registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_iss_state <= ARB;
            r_req_ready <= '0;
            r_wrreq     <= 1'b0;
            r_wr_data   <= '0;
            r_rr_ptr    <= '0;
            r_iss_idx   <= '0;
        end else begin
            r_iss_state <= w_iss_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_wrreq     <= w_wrreq_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_iss_idx   <= w_iss_idx_nxt;
        end
    end

    // Response FSM next state and next registered outputs
    always_comb begin
        w_rsp_state_nxt = r_rsp_state;
        w_rdreq_nxt     = 1'b0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_orphan        = 1'b0;
        case (r_rsp_state)
            R_IDLE: begin
                if (!rd_fifo_empty) begin
                    w_rsp_state_nxt = R_REQ;
                    w_rdreq_nxt     = 1'b1;
                end else begin
                    w_rsp_state_nxt = R_IDLE;
                end
            end
            R_REQ: begin
                // FIFO presents the word after the read edge
                w_rsp_state_nxt = R_CAP;
            end
            R_CAP: begin
                // Capture straight into the output register so the pulse
                // appears during R_OUT; an orphan word is never presented.
                w_rsp_state_nxt = R_OUT;
                if (r_outstanding != '0) begin
                    w_rsp_data_nxt          = rd_fifo_q;
                    w_rsp_valid_nxt[w_head] = 1'b1;
                end else begin
                    w_orphan = 1'b1;
                end
            end
            R_OUT: begin
                // Returning through R_IDLE gives the FIFO empty flag time to
                // settle before it is sampled again.
                w_rsp_state_nxt = R_IDLE;
            end
            default: begin
                w_rsp_state_nxt = R_IDLE;
            end
        endcase
    end

    // Pop the head tag at the end of the cycle in which it was delivered
    assign w_pop = (r_rsp_state == R_OUT) && (r_rsp_valid != '0);

    // Response FSM state register and its registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp_state <= R_IDLE;
            r_rdreq     <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_state <= w_rsp_state_nxt;
            r_rdreq     <= w_rdreq_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    // Tag queue storage, pointers and outstanding count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= r_iss_idx;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky orphan flag; a new orphan beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_orphan <= 1'b0;
        end else if (w_orphan) begin
            r_err_orphan <= 1'b1;
        end else if (err_clr) begin
            r_err_orphan <= 1'b0;
        end else begin
            r_err_orphan <= r_err_orphan;
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for spi_txn_arbiter.  Requesters, the write FIFO / SPI core and the
// read FIFO are modelled with queues.  Each word moved from the SPI model into
// the read FIFO pushes its expected owner and data into a scoreboard; a
// monitor pops the scoreboard whenever rsp_valid pulses.  Grants are checked
// against a circular "first valid after the last winner" rule.
// -----------------------------------------------------------------------------
module tb_spi_txn_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TD = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            wr_fifo_wrreq;
    logic [DW-1:0]   wr_fifo_data;
    logic            wr_fifo_full;
    logic            rd_fifo_rdreq;
    logic [DW-1:0]   rd_fifo_q;
    logic            rd_fifo_empty;
    logic [3:0]      outstanding;
    logic            err_orphan;
    logic            err_clr;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_fifo_wrreq(wr_fifo_wrreq), .wr_fifo_data(wr_fifo_data), .wr_fifo_full(wr_fifo_full),
        .rd_fifo_rdreq(rd_fifo_rdreq), .rd_fifo_q(rd_fifo_q), .rd_fifo_empty(rd_fifo_empty),
        .outstanding(outstanding), .err_orphan(err_orphan), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [7:0]  owner;
        logic [31:0] data;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] req_q [N][$];
    int          present_cnt [N];
    int          lat [N];
    int          neg_cnt = 0;
    logic [N-1:0] valid_at_edge = '0;
    int          rr_last = N - 1;
    int          issue_log [$];
    int          spi_pending = 0;
    bit          spi_en = 1'b1;
    bit          spi_one = 1'b0;
    int          spi_speed = 3;
    logic [31:0] rdq [$];
    logic [31:0] rsp_override [$];
    exp_t        exp_q [$];
    int          out_model = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          rsp_count = 0;
    int          grant_log [$];
    logic [3:0]  rsp_log [$];
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rsp_data = '0;
    bit          rand_full = 1'b0;
    bit          full_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Requester valid vector as sampled by the DUT at each rising edge
    initial begin
        forever begin
            @(posedge clk);
            valid_at_edge = req_valid;
        end
    end

    // Monitors, models and input drivers, all on the falling edge
    initial begin
        int   g;
        int   eg;
        exp_t e;
        logic [31:0] d;
        req_valid     = '0;
        req_data      = '0;
        rd_fifo_empty = 1'b1;
        rd_fifo_q     = '0;
        wr_fifo_full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            present_cnt[i] = 0;
            lat[i]         = 0;
        end
        forever begin
            @(negedge clk);
            neg_cnt++;
            check("outstanding", 64'(outstanding), 64'(out_model));

            // issue monitor
            if ((req_ready != '0) || wr_fifo_wrreq) begin
                check("grant_onehot", 64'(($countones(req_ready) == 1) && wr_fifo_wrreq), 64'd1);
                g = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                if (g >= 0) begin
                    eg = rr_pick(valid_at_edge, rr_last);
                    check("grant_idx", 64'(g), 64'(eg));
                    check("grant_had_word", 64'(req_q[g].size() > 0), 64'd1);
                    if (req_q[g].size() > 0) begin
                        check("wr_data", 64'(wr_fifo_data), 64'(req_q[g][0]));
                        void'(req_q[g].pop_front());
                    end
                    lat[g]         = neg_cnt - present_cnt[g];
                    present_cnt[g] = neg_cnt;
                    rr_last        = g;
                    issue_log.push_back(g);
                    grant_log.push_back(g);
                    spi_pending++;
                    wr_count++;
                    last_wr_data = wr_fifo_data;
                    out_model++;
                end
            end

            // response monitor
            if (rsp_valid != '0) begin
                rsp_count++;
                rsp_log.push_back(rsp_valid);
                last_rsp_data = rsp_data;
                check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 64'(rsp_valid), 64'(4'b0001 << e.owner));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                end
                if (out_model > 0) out_model--;
            end

            // read FIFO: non-show-ahead, data follows the read edge
            if (rd_fifo_rdreq) begin
                rd_count++;
                check("rd_nonempty", 64'(rdq.size() > 0), 64'd1);
                if (rdq.size() > 0) rd_fifo_q = rdq.pop_front();
            end

            // SPI core: returns words in issue order after a random delay
            if ((spi_en || spi_one) && (spi_pending > 0) && ($urandom_range(0, 3) <= spi_speed)) begin
                spi_one = 1'b0;
                spi_pending--;
                if (rsp_override.size() > 0) d = rsp_override.pop_front();
                else d = $urandom;
                rdq.push_back(d);
                if (issue_log.size() > 0) begin
                    e.owner = 8'(issue_log.pop_front());
                    e.data  = d;
                    exp_q.push_back(e);
                end
            end

            // drive inputs
            rd_fifo_empty = (rdq.size() == 0);
            wr_fifo_full  = rand_full ? ($urandom_range(0, 3) == 0) : full_force;
            for (int i = 0; i < N; i++) begin
                if (req_q[i].size() > 0) begin
                    if (!req_valid[i]) present_cnt[i] = neg_cnt;
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = req_q[i][0];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_data[i*DW +: DW]  = '0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_wr(input int target, input int budget);
        int t;
        t = 0;
        while ((wr_count < target) && (t < budget)) begin
            cyc(1);
            t++;
        end
        check("wait_wr_timeout", 64'(wr_count >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int  t;
        bit  busy;
        t = 0;
        busy = 1'b1;
        while (busy && (t < budget)) begin
            cyc(1);
            t++;
            busy = (exp_q.size() != 0) || (spi_pending != 0) || (rdq.size() != 0) || (out_model != 0);
            for (int i = 0; i < N; i++) if (req_q[i].size() != 0) busy = 1'b1;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        cyc(6);
    endtask

    task automatic check_reset();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_wrreq", 64'(wr_fifo_wrreq), 64'd0);
        check("rst_rdreq", 64'(rd_fifo_rdreq), 64'd0);
        check("rst_wr_data", 64'(wr_fifo_data), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);
    endtask

    // Directed scenarios followed by a randomized phase
    initial begin
        int base;
        int rd0;
        int rc0;
        int t;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_rsp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset_n = 1'b0;
        err_clr = 1'b0;
        cyc(3);
        check_reset();
        reset_n = 1'b1;
        cyc(2);

        // all four requesters hold valid: grants 0,1,2,3,0,...
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 2; w++)
                req_q[i].push_back(32'hB000_0000 + 32'(i * 16 + w));
        wait_wr(8, 200);
        for (int k = 0; k < 5; k++) check("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));
        wait_idle(500);
        for (int k = 0; k < 4; k++) check("rsp_order", 64'(rsp_log[k]), 64'(exp_rsp[k]));
        grant_log.delete();
        rsp_log.delete();

        // single requester 1
        rsp_override.push_back(32'h1234_5678);
        base = wr_count;
        req_q[1].push_back(32'hA5A5_0001);
        wait_wr(base + 1, 50);
        check("t1_latency", 64'(lat[1]), 64'd1);
        check("t1_grant", 64'(grant_log[0]), 64'd1);
        check("t1_wr_data", 64'(last_wr_data), 64'hA5A5_0001);
        wait_idle(200);
        check("t1_rsp_valid", 64'(rsp_log[0]), 64'b0010);
        check("t1_rsp_data", 64'(last_rsp_data), 64'h1234_5678);
        check("t1_outstanding", 64'(outstanding), 64'd0);

        // write FIFO full blocks all grants
        full_force = 1'b1;
        cyc(2);
        base = wr_count;
        for (int i = 0; i < N; i++) req_q[i].push_back(32'hC000_0000 + 32'(i));
        cyc(10);
        check("full_no_grant", 64'(wr_count), 64'(base));
        full_force = 1'b0;
        @(negedge clk);
        #1;
        check("full_release_0", 64'(wr_count), 64'(base));
        @(negedge clk);
        #1;
        check("full_release_1", 64'(wr_count), 64'(base + 1));
        wait_idle(500);

        // outstanding cap of TAG_DEPTH, then one response frees a slot
        spi_en = 1'b0;
        base = wr_count;
        for (int w = 0; w < TD + 1; w++) req_q[2].push_back(32'hD000_0000 + 32'(w));
        wait_wr(base + TD, 200);
        cyc(10);
        check("cap_outstanding", 64'(outstanding), 64'(TD));
        check("cap_no_ninth", 64'(wr_count), 64'(base + TD));
        spi_one = 1'b1;
        wait_wr(base + TD + 1, 100);
        cyc(3);
        check("cap_refill", 64'(outstanding), 64'(TD));
        spi_en = 1'b1;
        wait_idle(1000);

        // orphan word with nothing outstanding
        rd0 = rd_count;
        rc0 = rsp_count;
        rdq.push_back(32'hDEAD_BEEF);
        cyc(12);
        check("orphan_reads", 64'(rd_count), 64'(rd0 + 1));
        check("orphan_no_rsp", 64'(rsp_count), 64'(rc0));
        check("orphan_flag", 64'(err_orphan), 64'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("orphan_clr", 64'(err_orphan), 64'd0);

        // reset with three words in flight
        spi_en = 1'b0;
        base = wr_count;
        for (int i = 0; i < 3; i++) req_q[i].push_back(32'hE000_0000 + 32'(i));
        wait_wr(base + 3, 100);
        cyc(3);
        check("pre_reset_outstanding", 64'(outstanding), 64'd3);
        reset_n = 1'b0;
        cyc(1);
        out_model = 0;
        issue_log.delete();
        exp_q.delete();
        rr_last = N - 1;
        cyc(2);
        check_reset();
        reset_n = 1'b1;
        rd0 = rd_count;
        rc0 = rsp_count;
        spi_en = 1'b1;
        t = 0;
        while (((rd_count < rd0 + 3) || (rdq.size() != 0)) && (t < 200)) begin
            cyc(1);
            t++;
        end
        cyc(6);
        check("rst_orphan_reads", 64'(rd_count), 64'(rd0 + 3));
        check("rst_orphan_no_rsp", 64'(rsp_count), 64'(rc0));
        check("rst_orphan_flag", 64'(err_orphan), 64'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;

        // randomized traffic with random back-pressure and response delay
        rand_full = 1'b1;
        for (int n = 0; n < 300; n++) begin
            cyc(1);
            if ($urandom_range(0, 1) == 1) req_q[$urandom_range(0, N - 1)].push_back($urandom);
            if ((n % 50) == 0) spi_speed = $urandom_range(0, 3);
        end
        rand_full = 1'b0;
        spi_speed = 3;
        wait_idle(8000);
        check("final_outstanding", 64'(outstanding), 64'd0);
        check("final_err_orphan", 64'(err_orphan), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
